bus_cycle_decoder: RTL and testbench
====================================

# bus_cycle_decoder

- Decodes the 8088 max-mode status lines into bus cycle type and T-state, and drives the command strobes (memory/IO read and write, INTA) plus the IO_OR_M, IO_E and INTA_N qualifiers that the ready logic consumes.
- Consumes RDY from the ready logic to insert wait states (TW) and to end each cycle.
- Sits between the CPU core pins and the chipset decode (ready logic, PIC, IO decode, memory controller).
- All logic runs on the system clock, advanced by the cpu_clock_posedge / cpu_clock_negedge enable pulses.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: CPU-clock wait-state limit (only with BUS_CYCLE_TIMEOUT_EN); range 1..255.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- cpu_clock_posedge  in  1  one-clock pulse marking a CPU CLK rising edge
- cpu_clock_negedge  in  1  one-clock pulse marking a CPU CLK falling edge
- S_N  in  3  CPU status S2..S0, active-low encoding, 3'b111 = passive
- RDY  in  1  synchronized ready from ready logic, 1 = ready
- ALE  out  1  address latch enable
- IO_OR_M  out  1  1 = current cycle is IO or INTA
- IO_E  out  1  IO command window
- INTA_N  out  1  interrupt acknowledge strobe, active-low
- IOR_N, IOW_N, MEMR_N, MEMW_N  out  1 each  command strobes, active-low
- HALT  out  1  halt status seen
- BUS_STATE  out  3  0 IDLE, 1 T1, 2 T2, 3 T3, 4 TW, 5 T4
- BUS_TIMEOUT  out  1  one-clock pulse on forced cycle end (macro only)

## Operation
- States advance only on clocks where cpu_clock_posedge = 1, except ALE clear (negedge pulse).
- Status decode:
  - 000 INTA
  - 001 IO read
  - 010 IO write
  - 011 halt
  - 100 code fetch (MEMR)
  - 101 mem read
  - 110 mem write
  - 111 passive
- IDLE or T4, S_N != 111 at posedge: latch type, go T1, ALE = 1.
  - If the type is halt: set HALT = 1, stay in IDLE; HALT clears on the next non-halt cycle start.
- T1 -> T2 -> T3 unconditionally on successive posedges.
- T3 or TW:
  - RDY = 1 at posedge: go T4.
  - RDY = 0 at posedge: go TW.
- T4 -> T1 if S_N active (back-to-back cycle), else IDLE.
- Command strobe for the latched type is low in T2, T3 and TW; it rises on the posedge entering T4.
- IO_E = 1 in T2/T3/TW for IO read/write only.
- INTA_N = 0 in T2/T3/TW for INTA only.
- IO_OR_M = 1 from T1 through T4 for IO and INTA cycles, 0 otherwise; it stays unchanged through T4.
- Two back-to-back INTA cycles produce two separate INTA_N pulses, each with the T4/T1 high gap.
- S_N changes mid-cycle (T1..TW) are ignored; only the T1 latch counts.

## Timing
- Reset (reset_n = 0, immediate):
  - BUS_STATE = IDLE; ALE = 0; IO_OR_M = 0; IO_E = 0; HALT = 0; BUS_TIMEOUT = 0.
  - INTA_N, IOR_N, IOW_N, MEMR_N, MEMW_N = 1.
- Reset asserted mid-cycle aborts the cycle with no T4 and no timeout pulse.
- ALE:
  - Set on the clock of the posedge pulse entering T1.
  - Cleared on the first cpu_clock_negedge pulse after it (high for half a CPU clock).
- Strobes and qualifiers are registered; they change one system clock after the enabling pulse clock.
- Minimum cycle is 4 CPU clocks (T1..T4); each RDY = 0 sample adds exactly one TW.
- A posedge pulse and a negedge pulse on the same clock never occur. If they do, the posedge action wins and the negedge action is dropped.

## Configuration
- BUS_CYCLE_TIMEOUT_EN defined:
  - An 8-bit counter counts TW states.
  - When the count reaches TIMEOUT_CYCLES with RDY still 0, the next posedge forces T4 and pulses BUS_TIMEOUT for one clock.
  - The counter clears on leaving TW.
- BUS_CYCLE_TIMEOUT_EN undefined:
  - No counter; TW holds indefinitely while RDY = 0.
  - BUS_TIMEOUT is tied to 0.

## Test plan
- Mem read, RDY = 1: S_N = 101 at posedge 1 gives T1, T2, T3, T4.
  - MEMR_N low for exactly T2 and T3.
  - ALE high for half a CPU clock.
  - IO_OR_M = 0.
- IO write, RDY low for 2 samples: S_N = 010.
  - BUS_STATE passes T3, TW, TW, T4.
  - IOW_N and IO_E active 4 CPU clocks; IO_OR_M = 1 from T1 through T4.
- Double INTA: two back-to-back S_N = 000 cycles.
  - Two INTA_N low pulses of 2 CPU clocks each, separated by T4/T1.
  - IO_OR_M = 1 throughout.
- Halt then passive: S_N = 011 gives HALT = 1, no strobes, BUS_STATE stays IDLE; the next 101 cycle clears HALT.
- Reset mid-TW: reset_n low during TW gives all outputs at reset values immediately; after release S_N = 111 holds IDLE.
- Timeout (macro defined, TIMEOUT_CYCLES = 3): RDY held 0.
  - Exactly 3 TW, then T4.
  - BUS_TIMEOUT is a 1-clock pulse.
  - Without the macro, TW persists for 300 CPU clocks.

Source files
------------

// File: rtl/bus_cycle_decoder.sv
// 8088 max-mode status decoder: latches the cycle type at T1, walks T1..T4 with RDY-driven TW, drives registered strobes.
// Optional BUS_CYCLE_TIMEOUT_EN forces T4 after TIMEOUT_CYCLES wait states and pulses BUS_TIMEOUT.
module bus_cycle_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       cpu_clock_posedge,
  input  logic       cpu_clock_negedge,
  input  logic [2:0] S_N,
  input  logic       RDY,
  output logic       ALE,
  output logic       IO_OR_M,
  output logic       IO_E,
  output logic       INTA_N,
  output logic       IOR_N,
  output logic       IOW_N,
  output logic       MEMR_N,
  output logic       MEMW_N,
  output logic       HALT,
  output logic [2:0] BUS_STATE,
  output logic       BUS_TIMEOUT
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_TW   = 3'd4,
    ST_T4   = 3'd5
  } state_t;

  localparam logic [2:0] LP_INTA    = 3'b000;
  localparam logic [2:0] LP_IOR     = 3'b001;
  localparam logic [2:0] LP_IOW     = 3'b010;
  localparam logic [2:0] LP_HALT    = 3'b011;
  localparam logic [2:0] LP_CODE    = 3'b100;
  localparam logic [2:0] LP_MEMR    = 3'b101;
  localparam logic [2:0] LP_MEMW    = 3'b110;
  localparam logic [2:0] LP_PASSIVE = 3'b111;

  state_t     r_state, w_next_state;
  logic [2:0] r_type, w_next_type;
  logic       w_start, w_halt_set, w_timeout_hit;
  logic       w_cmd_win, w_in_cycle;
  logic       w_is_io, w_is_inta, w_is_memrd, w_is_memwr;
  logic       r_ale, r_io_or_m, r_io_e, r_inta_n, r_ior_n, r_iow_n, r_memr_n, r_memw_n, r_halt;

`ifdef BUS_CYCLE_TIMEOUT_EN
  logic [7:0] r_tw_cnt;
  logic       r_bus_timeout;

  assign w_timeout_hit = (r_state == ST_TW) && (r_tw_cnt >= 8'(TIMEOUT_CYCLES));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_tw_cnt      <= 8'd0;
      r_bus_timeout <= 1'b0;
    end else begin
      r_bus_timeout <= cpu_clock_posedge && w_timeout_hit && !RDY;
      if (cpu_clock_posedge) begin
        if (w_next_state != ST_TW)
          r_tw_cnt <= 8'd0;
        else if (r_state != ST_TW)
          r_tw_cnt <= 8'd1;
        else if (r_tw_cnt != 8'hFF)
          r_tw_cnt <= r_tw_cnt + 8'd1;
      end
    end
  end

  assign BUS_TIMEOUT = r_bus_timeout;
`else
  logic w_unused_cfg;
  assign w_unused_cfg  = ^8'(TIMEOUT_CYCLES);
  assign w_timeout_hit = 1'b0;
  assign BUS_TIMEOUT   = 1'b0;
`endif

  always_comb begin
    w_next_state = r_state;
    w_next_type  = r_type;
    w_start      = 1'b0;
    w_halt_set   = 1'b0;
    if (cpu_clock_posedge) begin
      case (r_state)
        ST_IDLE, ST_T4: begin
          w_next_state = ST_IDLE;
          if (S_N == LP_HALT) begin
            w_halt_set = 1'b1;
          end else if (S_N != LP_PASSIVE) begin
            w_next_state = ST_T1;
            w_next_type  = S_N;
            w_start      = 1'b1;
          end
        end
        ST_T1:        w_next_state = ST_T2;
        ST_T2:        w_next_state = ST_T3;
        ST_T3, ST_TW: w_next_state = (RDY || w_timeout_hit) ? ST_T4 : ST_TW;
        default:      w_next_state = ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they land on the same edge as BUS_STATE.
  assign w_cmd_win  = (w_next_state == ST_T2) || (w_next_state == ST_T3) || (w_next_state == ST_TW);
  assign w_in_cycle = (w_next_state != ST_IDLE);
  assign w_is_io    = (w_next_type == LP_IOR) || (w_next_type == LP_IOW);
  assign w_is_inta  = (w_next_type == LP_INTA);
  assign w_is_memrd = (w_next_type == LP_CODE) || (w_next_type == LP_MEMR);
  assign w_is_memwr = (w_next_type == LP_MEMW);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_type    <= LP_PASSIVE;
      r_ale     <= 1'b0;
      r_io_or_m <= 1'b0;
      r_io_e    <= 1'b0;
      r_inta_n  <= 1'b1;
      r_ior_n   <= 1'b1;
      r_iow_n   <= 1'b1;
      r_memr_n  <= 1'b1;
      r_memw_n  <= 1'b1;
      r_halt    <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_type    <= w_next_type;
      r_io_or_m <= w_in_cycle && (w_is_io || w_is_inta);
      r_io_e    <= w_cmd_win && w_is_io;
      r_inta_n  <= !(w_cmd_win && w_is_inta);
      r_ior_n   <= !(w_cmd_win && (w_next_type == LP_IOR));
      r_iow_n   <= !(w_cmd_win && (w_next_type == LP_IOW));
      r_memr_n  <= !(w_cmd_win && w_is_memrd);
      r_memw_n  <= !(w_cmd_win && w_is_memwr);
      if (w_halt_set)
        r_halt <= 1'b1;
      else if (w_start)
        r_halt <= 1'b0;
      // A coincident negedge pulse is dropped so ALE always spans a full half clock.
      if (w_start)
        r_ale <= 1'b1;
      else if (cpu_clock_negedge && !cpu_clock_posedge)
        r_ale <= 1'b0;
    end
  end

  assign ALE       = r_ale;
  assign IO_OR_M   = r_io_or_m;
  assign IO_E      = r_io_e;
  assign INTA_N    = r_inta_n;
  assign IOR_N     = r_ior_n;
  assign IOW_N     = r_iow_n;
  assign MEMR_N    = r_memr_n;
  assign MEMW_N    = r_memw_n;
  assign HALT      = r_halt;
  assign BUS_STATE = r_state;

endmodule

// File: tb/tb_bus_cycle_decoder.sv
// Directed bench for bus_cycle_decoder: vector table of CPU clocks plus reset, collision and wait-state sequences.
module tb_bus_cycle_decoder;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       cpu_clock_posedge, cpu_clock_negedge;
  logic [2:0] S_N;
  logic       RDY;
  logic       ALE, IO_OR_M, IO_E, INTA_N, IOR_N, IOW_N, MEMR_N, MEMW_N, HALT, BUS_TIMEOUT;
  logic [2:0] BUS_STATE;

  int n_checks = 0;
  int n_fail   = 0;

  bus_cycle_decoder #(.TIMEOUT_CYCLES(3)) dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_clock_posedge(cpu_clock_posedge), .cpu_clock_negedge(cpu_clock_negedge),
    .S_N(S_N), .RDY(RDY),
    .ALE(ALE), .IO_OR_M(IO_OR_M), .IO_E(IO_E), .INTA_N(INTA_N),
    .IOR_N(IOR_N), .IOW_N(IOW_N), .MEMR_N(MEMR_N), .MEMW_N(MEMW_N),
    .HALT(HALT), .BUS_STATE(BUS_STATE), .BUS_TIMEOUT(BUS_TIMEOUT)
  );

  always #5 clock = ~clock;

  localparam logic [4:0] A_NONE = 5'b00000;
  localparam logic [4:0] A_INTA = 5'b10000;
  localparam logic [4:0] A_IOR  = 5'b01000;
  localparam logic [4:0] A_IOW  = 5'b00100;
  localparam logic [4:0] A_MEMR = 5'b00010;
  localparam logic [4:0] A_MEMW = 5'b00001;

  typedef struct {
    logic [2:0]  s_n;
    logic        rdy;
    logic [11:0] exp;
  } vec_t;

  // Packing order: {BUS_STATE, ALE, IO_OR_M, IO_E, INTA_N, IOR_N, IOW_N, MEMR_N, MEMW_N, HALT}
  function automatic logic [11:0] ex(input int st, input bit ale, input bit ioorm, input bit ioe,
                                     input logic [4:0] act, input bit halt);
    return {3'(st), ale, ioorm, ioe, ~act, halt};
  endfunction

  function automatic logic [11:0] outs();
    return {BUS_STATE, ALE, IO_OR_M, IO_E, INTA_N, IOR_N, IOW_N, MEMR_N, MEMW_N, HALT};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic cyc_pos();
    cpu_clock_posedge = 1'b1;
    @(posedge clock); #1;
    cpu_clock_posedge = 1'b0;
  endtask

  task automatic cyc_rest();
    @(posedge clock); #1;
    cpu_clock_negedge = 1'b1;
    @(posedge clock); #1;
    cpu_clock_negedge = 1'b0;
    @(posedge clock); #1;
  endtask

  vec_t vecs[$];

  task automatic addv(input logic [2:0] s, input logic r, input logic [11:0] e);
    vec_t v;
    v.s_n = s; v.rdy = r; v.exp = e;
    vecs.push_back(v);
  endtask

  initial begin
    int tw_cnt;
    bit seen_t4;
    int bad;

    reset_n = 1'b0; cpu_clock_posedge = 1'b0; cpu_clock_negedge = 1'b0;
    S_N = 3'b111; RDY = 1'b1;

    // Memory read, zero wait states; mid-cycle S_N changes must be ignored.
    addv(3'b101, 1, ex(1, 1, 0, 0, A_NONE, 0));
    addv(3'b111, 1, ex(2, 0, 0, 0, A_MEMR, 0));
    addv(3'b111, 1, ex(3, 0, 0, 0, A_MEMR, 0));
    addv(3'b111, 1, ex(5, 0, 0, 0, A_NONE, 0));
    addv(3'b111, 1, ex(0, 0, 0, 0, A_NONE, 0));
    // IO write with two wait states.
    addv(3'b010, 1, ex(1, 1, 1, 0, A_NONE, 0));
    addv(3'b101, 1, ex(2, 0, 1, 1, A_IOW,  0));
    addv(3'b111, 0, ex(3, 0, 1, 1, A_IOW,  0));
    addv(3'b111, 0, ex(4, 0, 1, 1, A_IOW,  0));
    addv(3'b111, 0, ex(4, 0, 1, 1, A_IOW,  0));
    addv(3'b111, 1, ex(5, 0, 1, 0, A_NONE, 0));
    addv(3'b111, 1, ex(0, 0, 0, 0, A_NONE, 0));
    // Back-to-back INTA.
    addv(3'b000, 1, ex(1, 1, 1, 0, A_NONE, 0));
    addv(3'b111, 1, ex(2, 0, 1, 0, A_INTA, 0));
    addv(3'b111, 1, ex(3, 0, 1, 0, A_INTA, 0));
    addv(3'b000, 1, ex(5, 0, 1, 0, A_NONE, 0));
    addv(3'b000, 1, ex(1, 1, 1, 0, A_NONE, 0));
    addv(3'b111, 1, ex(2, 0, 1, 0, A_INTA, 0));
    addv(3'b111, 1, ex(3, 0, 1, 0, A_INTA, 0));
    addv(3'b111, 1, ex(5, 0, 1, 0, A_NONE, 0));
    addv(3'b111, 1, ex(0, 0, 0, 0, A_NONE, 0));
    // Memory write followed back-to-back by IO read.
    addv(3'b110, 1, ex(1, 1, 0, 0, A_NONE, 0));
    addv(3'b111, 1, ex(2, 0, 0, 0, A_MEMW, 0));
    addv(3'b111, 1, ex(3, 0, 0, 0, A_MEMW, 0));
    addv(3'b111, 1, ex(5, 0, 0, 0, A_NONE, 0));
    addv(3'b001, 1, ex(1, 1, 1, 0, A_NONE, 0));
    addv(3'b111, 1, ex(2, 0, 1, 1, A_IOR,  0));
    addv(3'b111, 1, ex(3, 0, 1, 1, A_IOR,  0));
    addv(3'b111, 1, ex(5, 0, 1, 0, A_NONE, 0));
    addv(3'b111, 1, ex(0, 0, 0, 0, A_NONE, 0));
    // Code fetch, then halt from T4, halt held, then a mem read clears HALT.
    addv(3'b100, 1, ex(1, 1, 0, 0, A_NONE, 0));
    addv(3'b111, 1, ex(2, 0, 0, 0, A_MEMR, 0));
    addv(3'b111, 1, ex(3, 0, 0, 0, A_MEMR, 0));
    addv(3'b111, 1, ex(5, 0, 0, 0, A_NONE, 0));
    addv(3'b011, 1, ex(0, 0, 0, 0, A_NONE, 1));
    addv(3'b011, 1, ex(0, 0, 0, 0, A_NONE, 1));
    addv(3'b111, 1, ex(0, 0, 0, 0, A_NONE, 1));
    addv(3'b101, 1, ex(1, 1, 0, 0, A_NONE, 0));
    addv(3'b111, 1, ex(2, 0, 0, 0, A_MEMR, 0));
    addv(3'b111, 1, ex(3, 0, 0, 0, A_MEMR, 0));
    addv(3'b111, 1, ex(5, 0, 0, 0, A_NONE, 0));
    addv(3'b111, 1, ex(0, 0, 0, 0, A_NONE, 0));

    repeat (3) @(posedge clock);
    #1;
    chk("reset_outputs", 32'(outs()), 32'(ex(0, 0, 0, 0, A_NONE, 0)));
    chk("reset_timeout", 32'(BUS_TIMEOUT), 32'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    foreach (vecs[i]) begin
      S_N = vecs[i].s_n;
      RDY = vecs[i].rdy;
      cyc_pos();
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
      cyc_rest();
      chk($sformatf("vec%0d_ale_clear", i), 32'(ALE), 32'd0);
    end

    // Reset in the middle of a wait state aborts the cycle immediately.
    S_N = 3'b001; RDY = 1'b0;
    repeat (4) begin cyc_pos(); S_N = 3'b111; cyc_rest(); end
    chk("pre_reset_in_tw", 32'(BUS_STATE), 32'd4);
    #2 reset_n = 1'b0;
    #1;
    chk("reset_mid_tw", 32'(outs()), 32'(ex(0, 0, 0, 0, A_NONE, 0)));
    chk("reset_mid_tw_timeout", 32'(BUS_TIMEOUT), 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1; RDY = 1'b1;
    repeat (3) begin cyc_pos(); cyc_rest(); end
    chk("idle_after_reset", 32'(outs()), 32'(ex(0, 0, 0, 0, A_NONE, 0)));

    // Coincident posedge/negedge pulses: posedge action wins, ALE survives.
    S_N = 3'b101; RDY = 1'b0;
    cyc_pos();
    S_N = 3'b111;
    @(posedge clock); #1;
    cpu_clock_posedge = 1'b1; cpu_clock_negedge = 1'b1;
    @(posedge clock); #1;
    cpu_clock_posedge = 1'b0; cpu_clock_negedge = 1'b0;
    chk("collision_state", 32'(BUS_STATE), 32'd2);
    chk("collision_ale_kept", 32'(ALE), 32'd1);
    cyc_rest();
    chk("collision_ale_cleared", 32'(ALE), 32'd0);

`ifdef BUS_CYCLE_TIMEOUT_EN
    tw_cnt = 0; seen_t4 = 0; bad = 0;
    for (int k = 0; k < 20 && !seen_t4; k++) begin
      cyc_pos();
      if (BUS_STATE == 3'd4) begin
        tw_cnt++;
        if (BUS_TIMEOUT !== 1'b0) bad++;
      end else if (BUS_STATE == 3'd5) begin
        seen_t4 = 1;
        chk("timeout_pulse_high", 32'(BUS_TIMEOUT), 32'd1);
        @(posedge clock); #1;
        chk("timeout_pulse_one_clock", 32'(BUS_TIMEOUT), 32'd0);
      end
      if (!seen_t4) cyc_rest();
    end
    chk("timeout_t4_reached", 32'(seen_t4), 32'd1);
    chk("timeout_tw_count", 32'(tw_cnt), 32'd3);
    chk("timeout_no_early_pulse", 32'(bad), 32'd0);
`else
    tw_cnt = 0; seen_t4 = 0; bad = 0;
    cyc_pos(); cyc_rest();
    chk("t3_before_wait", 32'(BUS_STATE), 32'd3);
    for (int k = 0; k < 300; k++) begin
      cyc_pos();
      if (BUS_STATE != 3'd4 || BUS_TIMEOUT !== 1'b0 || MEMR_N !== 1'b0) bad++;
      cyc_rest();
    end
    chk("tw_held_300", 32'(bad), 32'd0);
    RDY = 1'b1;
    cyc_pos();
    chk("t4_after_long_wait", 32'(BUS_STATE), 32'd5);
    chk("memr_released", 32'(MEMR_N), 32'd1);
    cyc_rest();
`endif
    RDY = 1'b1; S_N = 3'b111;
    cyc_pos();
    chk("idle_at_end", 32'(outs()), 32'(ex(0, 0, 0, 0, A_NONE, 0)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected end of test");
    $fatal(1);
  end

endmodule
